// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the oversampled UART word
//               receiver (byte FSM state encoding, data bits per character).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 2-flop rx synchronizer plus 8N1 byte FSM. All timing is
//               counted in sample_tick pulses; one FSM transition per tick.
// Ports       : clk, reset (async, active low), sample_tick (oversample
//               enable), rx (raw serial line) -> byte_data[7:0], byte_done
//               (1-cycle pulse, byte_data valid), frame_err (1-cycle pulse),
//               fsm_idle (FSM in IDLE), start_det (combinational, start edge
//               accepted this cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_done,
  output logic                 frame_err,
  output logic                 fsm_idle,
  output logic                 start_det
);

  localparam int              TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]   HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]   FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  logic                 sync1_q;
  logic                 rx_s_q;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 byte_done_q, byte_done_d;
  logic                 frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    frame_err_d = 1'b0;
    start_det   = 1'b0;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d    = START;
            tick_cnt_d = '0;
            start_det  = 1'b1;
          end
        end
        START: begin
          // Re-check at mid start bit; a high line here was only a glitch.
          if (tick_cnt_q == HALF_M1) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              state_d   = STOP;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            if (rx_s_q) begin
              byte_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        BREAK: begin
          // Hold off new start detection until the line returns high.
          if (rx_s_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign byte_data = shift_q;
  assign byte_done = byte_done_q;
  assign frame_err = frame_err_q;
  assign fsm_idle  = (state_q == IDLE);

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_rx
// Description : Oversampled 8N1 UART receiver that packs BYTES consecutive
//               bytes (first byte in bits [7:0]) into a 32-bit word, offered
//               on a valid/ready interface. Reports framing errors, inter-byte
//               timeouts and word overruns as 1-cycle pulses.
// Ports       : clk, reset (async, active low), sample_tick, rx,
//               word_data[31:0], word_valid, word_ready,
//               frame_err, timeout, overrun (pulses).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int BYTES         = 4,
  parameter int TIMEOUT_BAUDS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        rx,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        timeout,
  output logic        overrun
);

  localparam int               IDXW     = $clog2(BYTES + 1);
  localparam int               TO_LIMIT = TIMEOUT_BAUDS * OVERSAMPLE;
  localparam int               TOW      = $clog2(TO_LIMIT + 1);
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(BYTES - 1);
  localparam logic [TOW-1:0]   TO_LAST  = TOW'(TO_LIMIT - 1);

  logic [DATA_BITS-1:0] byte_data;
  logic                 byte_done;
  logic                 byte_frame_err;
  logic                 fsm_idle;
  logic                 start_det;

  uart_rx_byte #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_rx_byte (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .byte_data   (byte_data),
    .byte_done   (byte_done),
    .frame_err   (byte_frame_err),
    .fsm_idle    (fsm_idle),
    .start_det   (start_det)
  );

  logic [IDXW-1:0] byte_idx_q, byte_idx_d;
  logic [31:0]     asm_q, asm_d;
  logic [31:0]     asm_next;
  logic [31:0]     word_data_q, word_data_d;
  logic            word_valid_q, word_valid_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            overrun_q, overrun_d;
  logic            accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx_q   <= '0;
      asm_q        <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  // Partial word with the incoming byte merged in. Starting from zero on
  // the first byte keeps unused upper bytes clear when BYTES < 4.
  always_comb begin
    asm_next = (byte_idx_q == '0) ? 32'd0 : asm_q;
    for (int i = 0; i < 4; i++) begin
      if (i < BYTES && int'(byte_idx_q) == i) begin
        asm_next[i*DATA_BITS +: DATA_BITS] = byte_data;
      end
    end
  end

  assign accept = word_valid_q && word_ready;

  always_comb begin
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    to_cnt_d     = to_cnt_q;
    timeout_d    = 1'b0;
    overrun_d    = 1'b0;

    if (accept) begin
      word_valid_d = 1'b0;
    end

    if (byte_frame_err) begin
      byte_idx_d = '0;
    end else if (byte_done) begin
      if (byte_idx_q == LAST_IDX) begin
        byte_idx_d = '0;
        // A slot is free if empty or being drained this very cycle.
        if (!word_valid_q || accept) begin
          word_data_d  = asm_next;
          word_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
        asm_d      = asm_next;
      end
    end else if (byte_idx_q != '0 && fsm_idle && sample_tick) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_d  = 1'b1;
        byte_idx_d = '0;
        to_cnt_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    // A new start bit always restarts the idle measurement.
    if (start_det) begin
      to_cnt_d = '0;
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign frame_err  = byte_frame_err;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;

endmodule : uart_word_rx
`default_nettype wire

// File: tb/tb_uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_rx
// Description : Directed self-checking bench for uart_word_rx
//               (OVERSAMPLE=16, BYTES=4, TIMEOUT_BAUDS=20, sample_tick=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_tick = 1'b1;
  logic        rx = 1'b1;
  logic        word_ready = 1'b0;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        timeout;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int fe_seen  = 0;
  int to_seen  = 0;
  int ov_seen  = 0;
  int fe0, to0, ov0;

  uart_word_rx #(
    .OVERSAMPLE    (16),
    .BYTES         (4),
    .TIMEOUT_BAUDS (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .frame_err   (frame_err),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_err) fe_seen <= fe_seen + 1;
    if (timeout)   to_seen <= to_seen + 1;
    if (overrun)   ov_seen <= ov_seen + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(16);
    end
    rx = stop_bit;
    step(16);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i*8 +: 8], 1'b1);
    end
  endtask

  task automatic accept_word();
    word_ready = 1'b1;
    step(1);
    word_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_data",  word_data, 32'h0);
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_fe",    {31'd0, frame_err}, 32'd0);
    check("rst_to",    {31'd0, timeout}, 32'd0);
    check("rst_ov",    {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    step(5);

    // 1: basic word, held while ready=0, drops after accept
    send_word(32'h12345678);
    step(2);
    check("t1_valid", {31'd0, word_valid}, 32'd1);
    check("t1_data",  word_data, 32'h12345678);
    step(50);
    check("t1_valid_hold", {31'd0, word_valid}, 32'd1);
    check("t1_data_hold",  word_data, 32'h12345678);
    accept_word();
    check("t1_valid_drop", {31'd0, word_valid}, 32'd0);

    // 2: short low glitch is not a start bit
    fe0 = fe_seen;
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(40);
    check("t2_no_fe",    fe_seen - fe0, 32'd0);
    check("t2_no_valid", {31'd0, word_valid}, 32'd0);
    send_word(32'hA5C30F96);
    step(2);
    check("t2_data", word_data, 32'hA5C30F96);
    accept_word();

    // 3: framing error on second byte discards the partial word
    fe0 = fe_seen;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    step(4);
    check("t3_fe_once", fe_seen - fe0, 32'd1);
    check("t3_no_valid", {31'd0, word_valid}, 32'd0);
    send_word(32'hDEADBEEF);
    step(2);
    check("t3_valid", {31'd0, word_valid}, 32'd1);
    check("t3_data",  word_data, 32'hDEADBEEF);
    check("t3_fe_total", fe_seen - fe0, 32'd1);
    accept_word();

    // 4: second word while first unconsumed -> overrun, first kept
    ov0 = ov_seen;
    send_word(32'h11111111);
    send_word(32'h22222222);
    step(2);
    check("t4_ov_once", ov_seen - ov0, 32'd1);
    check("t4_data_kept", word_data, 32'h11111111);
    check("t4_valid", {31'd0, word_valid}, 32'd1);
    accept_word();
    step(1);
    check("t4_no_second", {31'd0, word_valid}, 32'd0);

    // 5: inter-byte timeout after 320 idle ticks
    to0 = to_seen;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    step(300);
    check("t5_no_to_early", to_seen - to0, 32'd0);
    step(30);
    check("t5_to_once", to_seen - to0, 32'd1);
    check("t5_no_valid", {31'd0, word_valid}, 32'd0);
    send_word(32'h44332211);
    step(2);
    check("t5_data", word_data, 32'h44332211);

    // 6: reset in the middle of the third byte's data bits
    fe0 = fe_seen;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    step(16 + 40);
    reset = 1'b0;
    rx = 1'b1;
    step(3);
    check("t6_rst_data",  word_data, 32'h0);
    check("t6_rst_valid", {31'd0, word_valid}, 32'd0);
    check("t6_rst_pulses", {29'd0, frame_err, timeout, overrun}, 32'd0);
    reset = 1'b1;
    step(200);
    check("t6_no_spurious", {31'd0, word_valid}, 32'd0);
    check("t6_no_fe", fe_seen - fe0, 32'd0);
    send_word(32'hCAFEF00D);
    step(2);
    check("t6_valid", {31'd0, word_valid}, 32'd1);
    check("t6_data",  word_data, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_word_rx
`default_nettype wire
